axi_lite_dmem: RTL

AXI4-Lite responder that services the core's data-memory requests issued by the MEM stage's load/store traffic. It owns a word-organised, byte-writable on-chip data RAM and returns write responses and read data over the five AXI4-Lite channels. One transaction is handled at a time, and writes take priority over reads.

---
 rtl/axi_pkg.sv | 13 +
 rtl/sram_1rw_be.sv | 30 +++
 rtl/axi_lite_dmem.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite widths and response encoding used by bus responders.
package axi_pkg;

   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module sram_1rw_be
   import axi_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                     clk,
   input  logic                     re,
   input  logic [AXI_STRB_BITS-1:0] we,
   input  logic [IDX_W-1:0]         addr,
   input  logic [AXI_DATA_BITS-1:0] wdata,
   output logic [AXI_DATA_BITS-1:0] rdata
);

   logic [AXI_DATA_BITS-1:0] mem [DEPTH_WORDS];

   // No reset on the array or the read register: contents survive rst.
   always_ff @(posedge clk) begin
      for (int i = 0; i < AXI_STRB_BITS; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/axi_lite_dmem.sv
// AXI4-Lite responder in front of the byte-writable data RAM; one transaction
// in flight at a time, writes win over reads.
//
//   state        | meaning
//   -------------+------------------------------------------------------------
//   S_IDLE       | ready for AW/W (write first) or AR
//   S_WR_COLLECT | one write half latched, waiting for the other
//   S_WR_RESP    | write committed, bvalid held until bready
//   S_RD_DATA    | read data registered, rvalid held until rready
module axi_lite_dmem
   import axi_pkg::*;
#(
   parameter int                       DEPTH_WORDS = 1024,
   parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR   = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AXI_ADDR_BITS-1:0] awaddr,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [AXI_DATA_BITS-1:0] wdata,
   input  logic [AXI_STRB_BITS-1:0] wstrb,
   input  logic                     wvalid,
   output logic                     wready,
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   input  logic [AXI_ADDR_BITS-1:0] araddr,
   input  logic                     arvalid,
   output logic                     arready,
   output logic [AXI_DATA_BITS-1:0] rdata,
   output logic [1:0]               rresp,
   output logic                     rvalid,
   input  logic                     rready
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [AXI_ADDR_BITS+1:0] RAM_BYTES = (AXI_ADDR_BITS+2)'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR_COLLECT,
      S_WR_RESP,
      S_RD_DATA
   } state_t;

   function automatic logic addr_ok(input logic [AXI_ADDR_BITS-1:0] a);
      logic [AXI_ADDR_BITS-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ({2'b00, off} < RAM_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_BITS-1:0] a);
      logic [AXI_ADDR_BITS-1:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   state_t                   state;
   logic                     aw_got;
   logic                     w_got;
   logic [AXI_ADDR_BITS-1:0] awaddr_q;
   logic [AXI_DATA_BITS-1:0] wdata_q;
   logic [AXI_STRB_BITS-1:0] wstrb_q;
   resp_t                    bresp_q;
   resp_t                    rresp_q;
   logic                     rd_err_q;

   logic                     aw_hs;
   logic                     w_hs;
   logic                     ar_hs;
   logic                     commit;
   logic [AXI_ADDR_BITS-1:0] wr_addr;
   logic [AXI_DATA_BITS-1:0] wr_data;
   logic [AXI_STRB_BITS-1:0] wr_strb;
   logic                     wr_ok;
   logic                     rd_ok;
   logic [AXI_STRB_BITS-1:0] ram_we;
   logic [IDX_W-1:0]         ram_addr;
   logic [AXI_DATA_BITS-1:0] ram_q;

   // Readies depend only on state, latched halves and (for AR) awvalid/wvalid.
   always_comb begin
      awready = !rst && (state == S_IDLE || state == S_WR_COLLECT) && !aw_got;
      wready  = !rst && (state == S_IDLE || state == S_WR_COLLECT) && !w_got;
      arready = !rst && (state == S_IDLE) && !awvalid && !wvalid && !aw_got && !w_got;
   end

   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign ar_hs   = arvalid && arready;
   assign commit  = (aw_hs || aw_got) && (w_hs || w_got) && (aw_hs || w_hs);
   assign wr_addr = aw_got ? awaddr_q : awaddr;
   assign wr_data = w_got ? wdata_q : wdata;
   assign wr_strb = w_got ? wstrb_q : wstrb;
   assign wr_ok   = addr_ok(wr_addr);
   assign rd_ok   = addr_ok(araddr);

   // Commit and AR never coincide, so the single port is shared by a plain mux.
   assign ram_we   = (commit && wr_ok) ? wr_strb : '0;
   assign ram_addr = commit ? addr_idx(wr_addr) : addr_idx(araddr);

   sram_1rw_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_sram (
      .clk   (clk),
      .re    (ar_hs && rd_ok),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wr_data),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         bresp_q  <= OKAY;
         rresp_q  <= OKAY;
         rd_err_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_WR_COLLECT: begin
               if (aw_hs) begin
                  aw_got   <= 1'b1;
                  awaddr_q <= awaddr;
               end
               if (w_hs) begin
                  w_got   <= 1'b1;
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
               end
               if (commit) begin
                  aw_got  <= 1'b0;
                  w_got   <= 1'b0;
                  bresp_q <= wr_ok ? OKAY : SLVERR;
                  state   <= S_WR_RESP;
               end else if (aw_hs || w_hs) begin
                  state <= S_WR_COLLECT;
               end else if (ar_hs) begin
                  rresp_q  <= rd_ok ? OKAY : SLVERR;
                  rd_err_q <= !rd_ok;
                  state    <= S_RD_DATA;
               end
            end
            S_WR_RESP: begin
               if (bready) begin
                  state <= S_IDLE;
               end
            end
            S_RD_DATA: begin
               if (rready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bvalid = !rst && (state == S_WR_RESP);
   assign rvalid = !rst && (state == S_RD_DATA);
   assign bresp  = bvalid ? bresp_q : OKAY;
   assign rresp  = rvalid ? rresp_q : OKAY;
   assign rdata  = (rvalid && !rd_err_q) ? ram_q : '0;

endmodule
